// File: rtl/spart_transmit.sv
// SPART transmitter: serialises processor-written bytes as 8N1 frames on TxD.
// A holding register lets the driver queue the next byte while the shift
// register is on the wire; back-to-back frames run with no idle gap.
module spart_transmit #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Enable,
  input  logic       IORW,
  input  logic [1:0] IOADDR,
  input  logic [7:0] DATA,
  output logic       TxD,
  output logic       TBR
);

  localparam logic [3:0] TICK_MAX = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_MAX  = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t     state, state_n;
  logic [3:0] tick, tick_n;
  logic [2:0] bitc, bit_n;
  logic [7:0] shift, shift_n;
  logic [7:0] holding;
  logic       hold_full;
  logic       txd_n;
  logic       load;
  logic       wr_strobe;

  assign wr_strobe = !IORW && (IOADDR == 2'b00);
  assign TBR       = !hold_full;

  // Next-state, counters and next TxD level; everything advances on Enable only.
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bit_n   = bitc;
    shift_n = shift;
    txd_n   = TxD;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (Enable && hold_full) begin
          load    = 1'b1;
          shift_n = holding;
          tick_n  = 4'd0;
          state_n = S_START;
          txd_n   = 1'b0;
        end
      end
      S_START: begin
        if (Enable) begin
          if (tick == TICK_MAX) begin
            tick_n  = 4'd0;
            bit_n   = 3'd0;
            state_n = S_DATA;
            txd_n   = shift[0];
          end else begin
            tick_n = tick + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (Enable) begin
          if (tick == TICK_MAX) begin
            shift_n = shift >> 1;
            tick_n  = 4'd0;
            if (bitc == BIT_MAX) begin
              state_n = S_STOP;
              txd_n   = 1'b1;
            end else begin
              bit_n = bitc + 3'd1;
              txd_n = shift[1];  // becomes shift[0] after this edge
            end
          end else begin
            tick_n = tick + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (Enable) begin
          if (tick == TICK_MAX) begin
            tick_n = 4'd0;
            if (hold_full) begin
              // chain straight into the next start bit, no idle gap
              load    = 1'b1;
              shift_n = holding;
              state_n = S_START;
              txd_n   = 1'b0;
            end else begin
              state_n = S_IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            tick_n = tick + 4'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  // FSM, counters, shift register and registered line output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tick  <= 4'd0;
      bitc  <= 3'd0;
      shift <= 8'd0;
      TxD   <= 1'b1;
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bitc  <= bit_n;
      shift <= shift_n;
      TxD   <= txd_n;
    end
  end

  // Holding register: a transfer empties it; a write fills it only if it was
  // already empty before the edge, so a write racing a transfer is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holding   <= 8'd0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (wr_strobe && !hold_full) begin
      holding   <= DATA;
      hold_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spart_transmit.sv
// Bench for spart_transmit: bus-access vector table, hand sequences for the
// multi-cycle cases, and a line monitor that decodes frames tick by tick and
// checks them against a queue of expected bytes.
module tb_spart_transmit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Enable = 1'b0;
  logic       IORW = 1'b1;
  logic [1:0] IOADDR = 2'b00;
  logic [7:0] DATA = 8'h00;
  logic       TxD;
  logic       TBR;

  spart_transmit dut (
    .clk(clk), .rst(rst), .Enable(Enable), .IORW(IORW),
    .IOADDR(IOADDR), .DATA(DATA), .TxD(TxD), .TBR(TBR)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] expq[$];
  int         fstart[$];
  int         nfr = 0;
  int         tk = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Line monitor: one TxD sample per Enable tick, taken mid-cycle.
  logic en_q = 1'b0;
  logic fr [0:159];
  logic in_fr = 1'b0;
  int   cnt = 0;

  always @(posedge clk) en_q <= Enable;

  always @(negedge clk) begin
    if (!rst) begin
      in_fr = 1'b0;
      cnt   = 0;
    end else if (en_q) begin
      tk++;
      if (!in_fr) begin
        if (TxD == 1'b0) begin
          in_fr = 1'b1;
          fr[0] = 1'b0;
          cnt   = 1;
          fstart.push_back(tk);
        end
      end else begin
        fr[cnt] = TxD;
        cnt++;
        if (cnt == 160) begin
          logic       ok;
          logic [7:0] by;
          ok = 1'b1;
          by = 8'h00;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < 16; k++)
              if (fr[b*16+k] !== fr[b*16]) ok = 1'b0;
          if (fr[0] !== 1'b0 || fr[144] !== 1'b1) ok = 1'b0;
          for (int b = 0; b < 8; b++) by[b] = fr[(b+1)*16];
          chk("frame_shape", {31'd0, ok}, 32'd1);
          if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_unexpected: got %0h want none", by);
          end else begin
            chk("frame_data", {24'd0, by}, {24'd0, expq.pop_front()});
          end
          nfr++;
          in_fr = 1'b0;
        end
      end
    end
  end

  // One clk cycle: drive at negedge, let the posedge apply, return at negedge.
  task automatic cyc(input logic en, input logic rw, input logic [1:0] a, input logic [7:0] d);
    Enable = en; IORW = rw; IOADDR = a; DATA = d;
    @(posedge clk);
    @(negedge clk);
    Enable = 1'b0; IORW = 1'b1; IOADDR = 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, 2'b00, 8'h00);
      cyc(1'b0, 1'b1, 2'b00, 8'h00);
    end
  endtask

  // Bus access: checks TBR beforehand and queues the byte when a write is due to land.
  task automatic acc(input string nm, input logic en, input logic rw, input logic [1:0] a,
                     input logic [7:0] d, input logic exp_tbr);
    chk(nm, {31'd0, TBR}, {31'd0, exp_tbr});
    if (!rw && a == 2'b00 && exp_tbr) expq.push_back(d);
    cyc(en, rw, a, d);
  endtask

  typedef struct {
    logic       rw;
    logic [1:0] a;
    logic [7:0] d;
    logic       exp_tbr;
    logic       exp_txd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic v;
    logic ok;
    int   n0;

    tbl[0] = '{1'b0, 2'b01, 8'h55, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 2'b00, 8'h55, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 2'b11, 8'h55, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 2'b10, 8'h55, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 2'b00, 8'hA5, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 2'b00, 8'h77, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 2'b00, 8'h55, 1'b0, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, TxD}, 32'd1);
    chk("rst_tbr", {31'd0, TBR}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_txd", {31'd0, TxD}, 32'd1);

    // bus access table with Enable low: only a 000 write to an empty buffer lands
    for (int i = 0; i < 7; i++) begin
      acc($sformatf("vec%0d_tbr", i), 1'b0, tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].exp_tbr);
      chk($sformatf("vec%0d_txd", i), {31'd0, TxD}, {31'd0, tbl[i].exp_txd});
    end
    chk("tbl_end_tbr", {31'd0, TBR}, 32'd0);

    // first Enable moves A5 into the shifter: start bit and TBR rise together
    ticks(1);
    chk("a5_start_txd", {31'd0, TxD}, 32'd0);
    chk("a5_start_tbr", {31'd0, TBR}, 32'd1);
    ticks(170);
    chk("a5_idle_txd", {31'd0, TxD}, 32'd1);
    chk("a5_nfr", nfr, 1);

    // write and Enable on one edge: transfer waits for the next Enable,
    // and a write on that transfer edge is dropped
    acc("same_edge_tbr", 1'b1, 1'b0, 2'b00, 8'h5A, 1'b1);
    chk("same_edge_txd", {31'd0, TxD}, 32'd1);
    chk("same_edge_tbr_after", {31'd0, TBR}, 32'd0);
    cyc(1'b0, 1'b1, 2'b00, 8'h00);
    acc("xfer_edge_tbr", 1'b1, 1'b0, 2'b00, 8'h99, 1'b0);
    chk("xfer_txd", {31'd0, TxD}, 32'd0);
    chk("xfer_tbr_after", {31'd0, TBR}, 32'd1);
    ticks(170);

    // back-to-back: second frame starts the tick after the first stop bit
    acc("b2b_w1", 1'b0, 1'b0, 2'b00, 8'h3C, 1'b1);
    ticks(40);
    acc("b2b_w2", 1'b0, 1'b0, 2'b00, 8'hFF, 1'b1);
    ticks(340);
    chk("b2b_nfr", nfr, 4);
    chk("b2b_gap", fstart[3] - fstart[2], 160);

    // overrun: 22 accepted, 33 dropped while TBR=0
    acc("ovr_w11", 1'b0, 1'b0, 2'b00, 8'h11, 1'b1);
    ticks(1);
    acc("ovr_w22", 1'b0, 1'b0, 2'b00, 8'h22, 1'b1);
    acc("ovr_w33", 1'b0, 1'b0, 2'b00, 8'h33, 1'b0);
    ticks(340);
    chk("ovr_nfr", nfr, 6);

    // Enable gap in the middle of bit 3 freezes the line
    acc("gate_w", 1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
    ticks(72);
    v  = TxD;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b1, 2'b00, 8'h00);
      if (TxD !== v) ok = 1'b0;
    end
    chk("gate_frozen", {31'd0, ok}, 32'd1);
    ticks(100);
    chk("gate_nfr", nfr, 7);

    // asynchronous reset mid-frame with a byte queued behind it
    acc("rst_w1", 1'b0, 1'b0, 2'b00, 8'hC3, 1'b1);
    ticks(20);
    acc("rst_w2", 1'b0, 1'b0, 2'b00, 8'h44, 1'b1);
    ticks(30);
    chk("rst_pre_tbr", {31'd0, TBR}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_txd", {31'd0, TxD}, 32'd1);
    chk("rst_mid_tbr", {31'd0, TBR}, 32'd1);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n0 = nfr;
    ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ticks(1);
      if (TxD !== 1'b1) ok = 1'b0;
    end
    chk("rst_idle_line", {31'd0, ok}, 32'd1);
    chk("rst_idle_nfr", nfr, n0);

    chk("leftover_expected", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spart_transmit.md
Name: spart_transmit

Overview:
- Transmit half of the SPART serial port. Serialises bytes written by the processor onto TxD as 8N1 frames: start bit, 8 data bits LSB first, 1 stop bit.
- Shares the Enable tick with the receiver. Enable is one clk-wide and arrives at 16x the baud rate; each serial bit lasts 16 Enable ticks.
- Double-buffered with a holding register and a shift register, so the driver can queue the next byte while the current frame is on the wire.

Parameters:
- DATA_BITS, 8, data bits per frame. Only 8 is supported; the DATA width is fixed at 8.
- OVERSAMPLE, 16, Enable ticks per serial bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately, independent of clk.
- Enable  input  1  16x baud tick, one clk wide.
- IORW  input  1  bus direction: 0 = write, 1 = read.
- IOADDR  input  2  bus address. 2'b00 is the data register.
- DATA  input  8  byte to transmit, sampled on a write strobe.
- TxD  output  1  serial line, registered, idles high.
- TBR  output  1  transmit buffer ready. 1 means the holding register is empty and a write will be accepted.

Behaviour:
- Write strobe: {IORW,IOADDR}==3'b000 at a clk rising edge.
  - If TBR=1: holding <= DATA, holding marked full, TBR=0 on the next cycle.
  - If TBR=0: the write is dropped and holding is unchanged.
- Reset (rst=0, any time, including mid-frame):
  - TxD=1, TBR=1, holding empty, state IDLE, tick counter 0, bit counter 0.
  - Any partial frame is abandoned. Line stays high until the next write.
- Outputs change only on clk rising edges or on reset assertion.
- FSM states are IDLE, START, DATA, STOP. The 4-bit tick counter and 3-bit bit counter advance only on edges where Enable=1.
- IDLE:
  - TxD=1.
  - On an Enable edge with holding full: shift <= holding, holding empty (TBR=1 the same edge), tick=0, go to START, TxD=0.
  - Enable=0 means no transfer; wait.
- START: TxD=0. When tick reaches 15 on an Enable edge: tick=0, bit=0, go to DATA, TxD=shift[0].
- DATA:
  - TxD=shift[0].
  - When tick reaches 15 on an Enable edge: shift >>= 1, tick=0.
  - If bit==7: go to STOP with TxD=1. Otherwise bit+1.
- STOP: TxD=1. When tick reaches 15 on an Enable edge:
  - If holding is full: load shift from holding, holding empty, go to START, TxD=0. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- Frame length is exactly 160 Enable ticks: 10 bits x 16.
- Latency:
  - Write at edge N leaves holding full after N.
  - TxD falls at the first Enable edge after N when the FSM is IDLE.
  - A write and an Enable on the same edge: the transfer happens at the next Enable edge, not the same one.
- Simultaneous events:
  - Write on the same edge as a holding-to-shift transfer: TBR was 0 before that edge, so the write is dropped. TBR=1 from the next cycle.
- Counter wrap: the tick counter wraps 15 -> 0 at each bit boundary. No other wrap occurs.
- Enable gaps: Enable=0 freezes all counters and TxD. The FSM holds its state indefinitely.
- Reads (IORW=1) have no effect on this block.

Test Plan:
- Reset: assert rst=0 mid-DATA of a frame -> TxD=1 and TBR=1 immediately. After release with no writes, TxD stays 1 for 400 Enable ticks.
- Single byte: write 8'hA5 while IDLE -> TxD = 0,1,0,1,0,0,1,0,1,1, each level held exactly 16 Enable ticks. TBR returns to 1 when START begins. Line idles afterwards.
- Back-to-back: write 8'h3C, then write 8'hFF while the first frame is in DATA -> second start bit begins on the tick immediately after the first stop bit. Total 320 ticks with no idle gap. Bits decode to 3C then FF.
- Overrun: write 8'h11, 8'h22, 8'h33 with no gaps while the 11 frame is transmitting -> 22 accepted, 33 dropped while TBR=0. Line carries 11 then 22 only.
- Enable gating: write 8'h00, hold Enable=0 for 50 clks in the middle of bit 3 -> TxD is frozen during the gap, and the frame resumes with bit 3 still totalling 16 ticks.
- Ignored accesses: {IORW,IOADDR}=3'b001 and 3'b100 with DATA=8'h55 -> TBR stays 1 and TxD stays 1.
